// File: rtl/adder_pkg.sv
// adder_pkg: shared op encodings, (g,p) pair type and
// Brent-Kung depth/latency helpers for the pipelined adder.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int bk_nlevels(input int width);
    return 2 * $clog2(width) - 1;
  endfunction

  function automatic int bk_latency(input int width,
                                    input int reg_every);
    int n;
    n = bk_nlevels(width);
    return (n + reg_every - 1) / reg_every + 1;
  endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// bk_prefix_cell: Brent-Kung (g,p) combine node.
// hi = upper group, lo = lower group, o = merged group.
module bk_prefix_cell
  import adder_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t o
);

  assign o.g = hi.g | (hi.p & lo.g);
  assign o.p = hi.p & lo.p;

endmodule

// File: rtl/bk_pipe_adder.sv
// bk_pipe_adder: pipelined Brent-Kung add/sub, saturation, flags, tag.
// in_* (valid/ready) -> prefix pipeline -> out_* (valid/ready).
module bk_pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 3,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  input  logic             in_sat,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LW  = $clog2(WIDTH);
  localparam int NL  = bk_nlevels(WIDTH);
  localparam int MSB = WIDTH - 1;

  if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_w
    $fatal(1, "bk_pipe_adder: WIDTH must be a power of two >= 4");
  end
  if ((REG_EVERY < 1) || (REG_EVERY > NL)) begin : g_bad_r
    $fatal(1, "bk_pipe_adder: REG_EVERY out of range 1..NLEVELS");
  end

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] p;
    logic             c0;
    logic             am;
    logic             bm;
    logic             sat;
    logic [TAG_W-1:0] tag;
  } side_t;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic             s0_v;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  logic             s0_c0;
  logic             s0_sat;
  logic [TAG_W-1:0] s0_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v   <= 1'b0;
      s0_a   <= '0;
      s0_b   <= '0;
      s0_c0  <= 1'b0;
      s0_sat <= 1'b0;
      s0_tag <= '0;
    end else if (en) begin
      s0_v   <= in_valid;
      s0_a   <= in_a;
      s0_b   <= (in_op == OP_SUB) ? ~in_b : in_b;
      s0_c0  <= (in_op == OP_SUB) ? 1'b1 : in_cin;
      s0_sat <= in_sat;
      s0_tag <= in_tag;
    end
  end

  // c0 is folded into bit 0 as the generate of a virtual bit -1,
  // so every prefix G[i:0] is directly the carry into bit i+1.
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g0;
  gp_t  [WIDTH-1:0] gp0;
  side_t            sb0;

  assign p0 = s0_a ^ s0_b;
  assign g0 = (s0_a & s0_b)
            | {{(WIDTH-1){1'b0}}, p0[0] & s0_c0};

  for (genvar i = 0; i < WIDTH; i++) begin : g_src
    assign gp0[i] = {g0[i], p0[i]};
  end

  assign sb0 = '{v: s0_v, p: p0, c0: s0_c0,
                 am: s0_a[MSB], bm: s0_b[MSB],
                 sat: s0_sat, tag: s0_tag};

  for (genvar l = 0; l < NL; l++) begin : g_lvl
    localparam int D = (l < LW) ? (1 << l)
                                : (1 << (2 * LW - 2 - l));
    gp_t [WIDTH-1:0] gi;
    gp_t [WIDTH-1:0] go;
    side_t           si;

    if (l == 0) begin : g_in
      assign gi = gp0;
      assign si = sb0;
    end else if ((l % REG_EVERY) == 0) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          gi <= '0;
          si <= '0;
        end else if (en) begin
          gi <= g_lvl[l-1].go;
          si <= g_lvl[l-1].si;
        end
      end
    end else begin : g_wire
      assign gi = g_lvl[l-1].go;
      assign si = g_lvl[l-1].si;
    end

    // Up-sweep builds power-of-two groups; down-sweep fills the
    // remaining prefixes from the nearest completed group below.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam bit UP = (l < LW) && (((i + 1) % (2 * D)) == 0);
      localparam bit DN = (l >= LW) && (((i + 1) % (2 * D)) == D)
                       && ((i + 1) > (2 * D));
      if (UP || DN) begin : g_cell
        bk_prefix_cell u_cell (
          .hi (gi[i]),
          .lo (gi[i-D]),
          .o  (go[i])
        );
      end else begin : g_pass
        assign go[i] = gi[i];
      end
    end
  end

  logic [WIDTH-1:0] gg;
  logic [WIDTH-1:0] unused_p;
  side_t            sf;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fin
    assign gg[i]       = g_lvl[NL-1].go[i].g;
    assign unused_p[i] = g_lvl[NL-1].go[i].p;
  end
  assign sf = g_lvl[NL-1].si;

  logic [WIDTH-1:0] cy;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] fin;
  logic             cout;
  logic             ovf;

  always_comb begin
    cy   = {gg[WIDTH-2:0], sf.c0};
    raw  = sf.p ^ cy;
    cout = gg[MSB];
    ovf  = (sf.am == sf.bm) && (raw[MSB] != sf.am);
    fin  = raw;
    if (sf.sat && ovf) begin
      fin = sf.am ? {1'b1, {(WIDTH-1){1'b0}}}
                  : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b1;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= sf.v;
      out_sum   <= fin;
      out_cout  <= cout;
      out_ovf   <= ovf;
      out_zero  <= (fin == '0);
      out_tag   <= sf.tag;
    end
  end

endmodule

// File: tb/tb_bk_pipe_adder.sv
// tb_bk_pipe_adder: three adder configs vs arithmetic reference model.
// Directed edge cases, streaming, backpressure and mid-stream reset.
module tb_bk_pipe_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        op;
  logic        sat;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  tag;
  int          sel;

  logic v32, v16, v64;
  assign v32 = in_valid && (sel == 0);
  assign v16 = in_valid && (sel == 1);
  assign v64 = in_valid && (sel == 2);

  logic        r32, ov32, c32, o32, z32;
  logic [31:0] s32;
  logic [3:0]  t32;
  logic        r16, ov16, c16, o16, z16;
  logic [15:0] s16;
  logic [3:0]  t16;
  logic        r64, ov64, c64, o64, z64;
  logic [63:0] s64;
  logic [3:0]  t64;

  bk_pipe_adder #(.WIDTH(32), .REG_EVERY(3), .TAG_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32),
    .in_a(a[31:0]), .in_b(b[31:0]), .in_cin(cin), .in_op(op),
    .in_sat(sat), .in_tag(tag), .out_valid(ov32),
    .out_ready(out_ready), .out_sum(s32), .out_cout(c32),
    .out_ovf(o32), .out_zero(z32), .out_tag(t32));

  bk_pipe_adder #(.WIDTH(16), .REG_EVERY(1), .TAG_W(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16),
    .in_a(a[15:0]), .in_b(b[15:0]), .in_cin(cin), .in_op(op),
    .in_sat(sat), .in_tag(tag), .out_valid(ov16),
    .out_ready(out_ready), .out_sum(s16), .out_cout(c16),
    .out_ovf(o16), .out_zero(z16), .out_tag(t16));

  bk_pipe_adder #(.WIDTH(64), .REG_EVERY(11), .TAG_W(4)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64),
    .in_a(a), .in_b(b), .in_cin(cin), .in_op(op),
    .in_sat(sat), .in_tag(tag), .out_valid(ov64),
    .out_ready(out_ready), .out_sum(s64), .out_cout(c64),
    .out_ovf(o64), .out_zero(z64), .out_tag(t64));

  logic        irdy, ov, co, of, zo;
  logic [63:0] sum;
  logic [3:0]  tg;

  always_comb begin
    irdy = r32; ov = ov32; co = c32; of = o32; zo = z32;
    sum = {32'd0, s32}; tg = t32;
    case (sel)
      1: begin
        irdy = r16; ov = ov16; co = c16; of = o16; zo = z16;
        sum = {48'd0, s16}; tg = t16;
      end
      2: begin
        irdy = r64; ov = ov64; co = c64; of = o64; zo = z64;
        sum = s64; tg = t64;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
    int          due;
  } exp_t;

  exp_t     q[$];
  int       tests = 0;
  int       fails = 0;
  int       cyc = 0;
  int       w = 32;
  int       lat = 4;
  bit       chk_lat = 1'b1;
  bit       acc = 1'b0;
  logic [3:0] tagc = 4'd0;

  function automatic logic [63:0] mask(input int wd);
    return (wd == 64) ? '1 : ((64'd1 << wd) - 64'd1);
  endfunction

  // Reference: raw sum by wide unsigned add, overflow by comparing
  // the exact signed result against the representable range.
  function automatic exp_t model(input int wd,
                                 input logic [63:0] ia,
                                 input logic [63:0] ib,
                                 input logic ic, iop, isat);
    exp_t e;
    logic [63:0] m, am, bm, bb;
    logic [64:0] full;
    logic signed [67:0] one, sa, sb, t, mx, mn;
    m    = mask(wd);
    am   = ia & m;
    bm   = ib & m;
    bb   = iop ? (~bm & m) : bm;
    full = {1'b0, am} + {1'b0, bb} + {64'd0, (iop ? 1'b1 : ic)};
    e.sum  = full[63:0] & m;
    e.cout = full[wd];
    one = 68'sd1;
    sa  = $signed({4'd0, am});
    if (am[wd-1]) sa = sa - (one <<< wd);
    sb  = $signed({4'd0, bm});
    if (bm[wd-1]) sb = sb - (one <<< wd);
    t   = iop ? (sa - sb) : (sa + sb + (ic ? one : 68'sd0));
    mx  = (one <<< (wd - 1)) - one;
    mn  = -(one <<< (wd - 1));
    e.ovf = (t > mx) || (t < mn);
    if (isat && e.ovf)
      e.sum = (t > mx) ? mx[63:0] : (mn[63:0] & m);
    e.zero = (e.sum == 64'd0);
    e.tag  = 4'd0;
    e.due  = 0;
    return e;
  endfunction

  function automatic logic [63:0] rnd(input int wd);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = '1;
      1: v = 64'd0;
      2: v = 64'd1 << (wd - 1);
      3: v = (64'd1 << (wd - 1)) - 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & mask(wd);
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s w=%0d: got %h want %h", nm, w, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc = in_valid && irdy;
    if (ov && out_ready) begin
      tests++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL spurious w=%0d: got result %h want none", w, sum);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", {63'd0, co}, {63'd0, e.cout});
        chk("ovf", {63'd0, of}, {63'd0, e.ovf});
        chk("zero", {63'd0, zo}, {63'd0, e.zero});
        chk("tag", {60'd0, tg}, {60'd0, e.tag});
        if (chk_lat) chk("latency", 64'(cyc), 64'(e.due));
      end
    end
    if (acc) begin
      e     = model(w, a, b, cin, op, sat);
      e.tag = tag;
      e.due = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue(input logic [63:0] ia, input logic [63:0] ib,
                       input logic ic, input logic iop,
                       input logic isat);
    a = ia; b = ib; cin = ic; op = iop; sat = isat;
    tag = tagc; in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc) break;
    end
    tests++;
    assert (acc) else begin
      fails++;
      $error("FAIL accept w=%0d: got no accept want accept", w);
    end
    tagc++;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 40 && q.size() != 0; k++) tick();
    tests++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL drain w=%0d: got %0d pending want 0", w, q.size());
    end
  endtask

  task automatic run_dir();
    logic [63:0] m, mn, mx;
    m  = mask(w);
    mn = 64'd1 << (w - 1);
    mx = mn - 64'd1;
    chk_lat = 1'b1;
    issue(m, 64'd0, 1'b1, OP_ADD, 1'b0);
    drain();
    issue(mx, 64'd1, 1'b0, OP_ADD, 1'b1);
    issue(mx, 64'd1, 1'b0, OP_ADD, 1'b0);
    issue(mn, 64'd1, 1'b1, OP_SUB, 1'b1);
    issue(mn, 64'd1, 1'b0, OP_SUB, 1'b0);
    issue(64'd5, 64'd5, 1'b0, OP_SUB, 1'b0);
    issue(mn, mn, 1'b0, OP_ADD, 1'b1);
    issue(m, m, 1'b1, OP_ADD, 1'b0);
    drain();
  endtask

  task automatic stream(input int n);
    chk_lat = 1'b1;
    for (int k = 0; k < n; k++)
      issue(rnd(w), rnd(w), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cin = 1'b0; op = OP_ADD; sat = 1'b0;
    a = '0; b = '0; tag = '0; sel = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk("rst_valid", {63'd0, ov}, 64'd0);
      chk("rst_sum", sum, 64'd0);
      chk("rst_zero", {63'd0, zo}, 64'd1);
      chk("rst_flags", {62'd0, co, of}, 64'd0);
      chk("rst_tag", {60'd0, tg}, 64'd0);
      chk("rst_ready", {63'd0, irdy}, 64'd1);
    end
    sel = 0; w = 32; lat = 4;
    tick();
    run_dir();
    stream(100);

    chk_lat = 1'b0;
    for (int k = 0; k < 6; k++)
      issue(rnd(w), rnd(w), 1'b0, OP_ADD, 1'b0);
    a = rnd(w); b = rnd(w);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ready", {63'd0, irdy}, 64'd0);
      chk("stall_valid", {63'd0, ov}, 64'd1);
      if (q.size() != 0) begin
        chk("stall_sum", sum, q[0].sum);
        chk("stall_tag", {60'd0, tg}, {60'd0, q[0].tag});
      end
      @(posedge clk);
      cyc++;
      #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      issue(rnd(w), rnd(w), 1'b1, OP_SUB, 1'b1);
    drain();

    chk_lat = 1'b1;
    for (int k = 0; k < 3; k++)
      issue(rnd(w), rnd(w), 1'b0, OP_ADD, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("pre_rst_valid", {63'd0, ov}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, ov}, 64'd0);
    chk("mid_rst_sum", sum, 64'd0);
    chk("mid_rst_zero", {63'd0, zo}, 64'd1);
    chk("mid_rst_ready", {63'd0, irdy}, 64'd1);
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("post_rst_valid", {63'd0, ov}, 64'd0);
    end
    run_dir();

    sel = 1; w = 16; lat = 8;
    tick();
    run_dir();
    stream(30);

    sel = 2; w = 64; lat = 2;
    tick();
    run_dir();
    stream(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
